vram_rd_arbiter: RTL and testbench

// Shares the single read port of the 1024x8 text VRAM (Gowin_SDPB_vram) between the LCD glyph fetcher and CPU reads.
// - LCD has priority; CPU reads take idle slots.
// - A tag pipeline routes each returned byte to the requester that issued it.
// - CPU writes pass straight to the VRAM write port.
// - Sits between the CPU/LCD logic and the ram wrapper; drives all v_* VRAM pins.

---
 rtl/vram_rd_arbiter.sv | 100 ++++++++++
 tb/tb_vram_rd_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_rd_arbiter.sv
// Shares the single read port of the 1024x8 text VRAM between the LCD glyph fetcher and CPU reads.
// Optional starvation guard for CPU reads is enabled by defining VRAM_ARB_FAIR_EN.
module vram_rd_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        MEMORY_CLK,
  input  logic        reset,
  input  logic        lcd_rd_req,
  input  logic [9:0]  lcd_rd_addr,
  output logic        lcd_rd_gnt,
  output logic        lcd_rd_valid,
  output logic [7:0]  lcd_rd_data,
  input  logic        cpu_rd_req,
  input  logic [9:0]  cpu_rd_addr,
  output logic        cpu_rd_gnt,
  output logic        cpu_rd_valid,
  output logic [7:0]  cpu_rd_data,
  input  logic        cpu_wr_en,
  input  logic [9:0]  cpu_wr_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        v_cea,
  output logic [9:0]  v_ada,
  output logic [7:0]  v_din,
  output logic        v_reseta,
  output logic        v_ceb,
  output logic [9:0]  v_adb,
  output logic        v_oce,
  output logic        v_resetb,
  input  logic [7:0]  v_dout
);

  localparam int unsigned CW = 8;
  localparam int unsigned LAST = READ_LATENCY - 1;

  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
    $error("vram_rd_arbiter: READ_LATENCY must be 1 or 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
    $error("vram_rd_arbiter: STARVE_LIMIT must be 1..255");
  end

  logic                    force_cpu;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [READ_LATENCY-1:0] tag_cpu;

`ifdef VRAM_ARB_FAIR_EN
  logic [CW-1:0] starve_cnt;

  // Counts consecutive cycles a CPU read has been waiting; saturates.
  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (cpu_rd_gnt || !cpu_rd_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != {CW{1'b1}}) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_cpu = (starve_cnt >= CW'(STARVE_LIMIT)) & cpu_rd_req;
`else
  assign force_cpu = 1'b0;
`endif

  // Combinational arbitration: LCD first unless the CPU has waited too long.
  assign lcd_rd_gnt = lcd_rd_req & ~force_cpu & ~reset;
  assign cpu_rd_gnt = cpu_rd_req & ~lcd_rd_gnt & ~reset;

  assign v_ceb    = lcd_rd_gnt | cpu_rd_gnt;
  assign v_adb    = cpu_rd_gnt ? cpu_rd_addr : lcd_rd_addr;
  assign v_oce    = 1'b1;
  assign v_resetb = reset;

  assign v_cea    = cpu_wr_en & ~reset;
  assign v_ada    = cpu_wr_addr;
  assign v_din    = cpu_wr_data;
  assign v_reseta = reset;

  // Tag pipe tracks which requester owns each read in flight through the RAM.
  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      tag_vld <= '0;
      tag_cpu <= '0;
    end else begin
      tag_vld[0] <= lcd_rd_gnt | cpu_rd_gnt;
      tag_cpu[0] <= cpu_rd_gnt;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_cpu[i] <= tag_cpu[i-1];
      end
    end
  end

  assign lcd_rd_valid = tag_vld[LAST] & ~tag_cpu[LAST] & ~reset;
  assign cpu_rd_valid = tag_vld[LAST] &  tag_cpu[LAST] & ~reset;
  assign lcd_rd_data  = v_dout;
  assign cpu_rd_data  = v_dout;

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Directed bench for vram_rd_arbiter with a behavioural read-first SDPB model (pipeline output register).
module tb_vram_rd_arbiter;

  localparam int unsigned RL = 2;
  localparam int unsigned SL = 8;

  logic       MEMORY_CLK = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rd_req = 1'b0;
  logic [9:0] lcd_rd_addr = '0;
  logic       lcd_rd_gnt, lcd_rd_valid;
  logic [7:0] lcd_rd_data;
  logic       cpu_rd_req = 1'b0;
  logic [9:0] cpu_rd_addr = '0;
  logic       cpu_rd_gnt, cpu_rd_valid;
  logic [7:0] cpu_rd_data;
  logic       cpu_wr_en = 1'b0;
  logic [9:0] cpu_wr_addr = '0;
  logic [7:0] cpu_wr_data = '0;
  logic       v_cea, v_reseta, v_ceb, v_oce, v_resetb;
  logic [9:0] v_ada, v_adb;
  logic [7:0] v_din, v_dout;

  int total = 0;
  int bad = 0;

  vram_rd_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .MEMORY_CLK(MEMORY_CLK), .reset(reset),
    .lcd_rd_req(lcd_rd_req), .lcd_rd_addr(lcd_rd_addr), .lcd_rd_gnt(lcd_rd_gnt),
    .lcd_rd_valid(lcd_rd_valid), .lcd_rd_data(lcd_rd_data),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .v_cea(v_cea), .v_ada(v_ada), .v_din(v_din), .v_reseta(v_reseta),
    .v_ceb(v_ceb), .v_adb(v_adb), .v_oce(v_oce), .v_resetb(v_resetb),
    .v_dout(v_dout)
  );

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  // Preload pattern: addr[7:0] ^ 0x5A, with 0x005 = 0xA5 and 0x3FF = 0x00.
  function automatic logic [7:0] pat(input logic [9:0] a);
    if (a == 10'h005) return 8'hA5;
    if (a == 10'h3FF) return 8'h00;
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] mem [1024];
  logic [7:0] rd_reg, out_reg;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
  end

  always @(posedge MEMORY_CLK) begin
    if (v_cea) mem[v_ada] <= v_din;
  end

  always @(posedge MEMORY_CLK) begin
    if (v_resetb) begin
      rd_reg  <= '0;
      out_reg <= '0;
    end else begin
      if (v_ceb) rd_reg <= mem[v_adb];
      if (v_oce) out_reg <= rd_reg;
    end
  end
  assign v_dout = (RL == 1) ? rd_reg : out_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge MEMORY_CLK);
    #1;
  endtask

  logic [9:0] t3_addr [16];
  logic       t3_cpu  [16];
  logic       fair;
  logic       exp_cpu;

  initial begin
`ifdef VRAM_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    // Reset state, with requests and a write strobe pending
    lcd_rd_req = 1'b1; cpu_rd_req = 1'b1; cpu_wr_en = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_lcd_gnt", 32'(lcd_rd_gnt), 0);
    chk("rst_cpu_gnt", 32'(cpu_rd_gnt), 0);
    chk("rst_ceb", 32'(v_ceb), 0);
    chk("rst_cea", 32'(v_cea), 0);
    chk("rst_valids", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);
    chk("rst_oce", 32'(v_oce), 1);
    chk("rst_resets", {30'd0, v_reseta, v_resetb}, 32'h3);
    cyc();
    reset = 1'b0; lcd_rd_req = 1'b0; cpu_rd_req = 1'b0; cpu_wr_en = 1'b0;
    cyc();

    // 1: single CPU read of 0x005
    cpu_rd_req = 1'b1; cpu_rd_addr = 10'h005; #1;
    chk("t1_cpu_gnt", 32'(cpu_rd_gnt), 1);
    chk("t1_lcd_gnt", 32'(lcd_rd_gnt), 0);
    chk("t1_adb", 32'(v_adb), 32'h005);
    cyc(); cpu_rd_req = 1'b0; #1;
    chk("t1_early_valid", 32'(cpu_rd_valid), 0);
    cyc(); #1;
    chk("t1_cpu_valid", 32'(cpu_rd_valid), 1);
    chk("t1_cpu_data", 32'(cpu_rd_data), 32'hA5);
    chk("t1_lcd_valid", 32'(lcd_rd_valid), 0);
    cyc(); #1;
    chk("t1_valid_drop", 32'(cpu_rd_valid), 0);

    // 2: simultaneous LCD 0x010 / CPU 0x020
    lcd_rd_req = 1'b1; lcd_rd_addr = 10'h010;
    cpu_rd_req = 1'b1; cpu_rd_addr = 10'h020; #1;
    chk("t2_lcd_first", {30'd0, lcd_rd_gnt, cpu_rd_gnt}, 32'h2);
    chk("t2_adb_lcd", 32'(v_adb), 32'h010);
    cyc(); lcd_rd_req = 1'b0; #1;
    chk("t2_cpu_next", {30'd0, lcd_rd_gnt, cpu_rd_gnt}, 32'h1);
    chk("t2_adb_cpu", 32'(v_adb), 32'h020);
    cyc(); cpu_rd_req = 1'b0; #1;
    chk("t2_lcd_valid", {30'd0, lcd_rd_valid, cpu_rd_valid}, 32'h2);
    chk("t2_lcd_data", 32'(lcd_rd_data), 32'h4A);
    cyc(); #1;
    chk("t2_cpu_valid", {30'd0, lcd_rd_valid, cpu_rd_valid}, 32'h1);
    chk("t2_cpu_data", 32'(cpu_rd_data), 32'h7A);
    cyc();

    // 3: 16 alternating back-to-back reads
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        t3_cpu[k]  = k[0];
        t3_addr[k] = k[0] ? 10'(12'h200 + k) : 10'(12'h100 + k);
        lcd_rd_req = ~k[0]; lcd_rd_addr = t3_addr[k];
        cpu_rd_req =  k[0]; cpu_rd_addr = t3_addr[k];
      end else begin
        lcd_rd_req = 1'b0; cpu_rd_req = 1'b0;
      end
      #1;
      if (k < 16) chk("t3_gnt", {30'd0, lcd_rd_gnt, cpu_rd_gnt}, t3_cpu[k] ? 32'h1 : 32'h2);
      if (k >= 2) begin
        chk("t3_valid", {30'd0, lcd_rd_valid, cpu_rd_valid}, t3_cpu[k-2] ? 32'h1 : 32'h2);
        chk("t3_data", 32'(t3_cpu[k-2] ? cpu_rd_data : lcd_rd_data), 32'(pat(t3_addr[k-2])));
      end
      cyc();
    end
    #1;
    chk("t3_idle", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);

    // 4: same-cycle write/read of 0x3FF returns old data
    cpu_wr_en = 1'b1; cpu_wr_addr = 10'h3FF; cpu_wr_data = 8'h3C;
    cpu_rd_req = 1'b1; cpu_rd_addr = 10'h3FF; #1;
    chk("t4_wr_port", {13'd0, v_cea, v_ada, v_din}, {13'd0, 1'b1, 10'h3FF, 8'h3C});
    chk("t4_gnt", 32'(cpu_rd_gnt), 1);
    cyc(); cpu_wr_en = 1'b0; cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("t4_old_valid", 32'(cpu_rd_valid), 1);
    chk("t4_old_data", 32'(cpu_rd_data), 32'h00);
    cpu_rd_req = 1'b1;
    cyc(); cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("t4_new_valid", 32'(cpu_rd_valid), 1);
    chk("t4_new_data", 32'(cpu_rd_data), 32'h3C);
    cyc();

    // 5: reset with two reads in flight
    lcd_rd_req = 1'b1; lcd_rd_addr = 10'h030;
    cyc(); lcd_rd_req = 1'b0; cpu_rd_req = 1'b1; cpu_rd_addr = 10'h040; #1;
    chk("t5_cpu_gnt", 32'(cpu_rd_gnt), 1);
    cyc(); cpu_rd_req = 1'b0; reset = 1'b1; #1;
    chk("t5_rst_c0", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);
    cyc(); #1;
    chk("t5_rst_c1", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);
    cyc(); reset = 1'b0; #1;
    chk("t5_post_c0", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);
    cyc(); #1;
    chk("t5_post_c1", {30'd0, lcd_rd_valid, cpu_rd_valid}, 0);
    cpu_rd_req = 1'b1; cpu_rd_addr = 10'h001; #1;
    chk("t5_rd_gnt", 32'(cpu_rd_gnt), 1);
    cyc(); cpu_rd_req = 1'b0;
    cyc(); #1;
    chk("t5_rd_valid", {30'd0, lcd_rd_valid, cpu_rd_valid}, 32'h1);
    chk("t5_rd_data", 32'(cpu_rd_data), 32'h5B);
    cyc();

    // 6: continuous LCD traffic against a held CPU request
    lcd_rd_req = 1'b1; lcd_rd_addr = 10'h050;
    cpu_rd_req = 1'b1; cpu_rd_addr = 10'h060;
    for (int i = 1; i <= 12; i++) begin
      #1;
      exp_cpu = fair && (i == 9);
      chk("t6_gnt", {30'd0, lcd_rd_gnt, cpu_rd_gnt}, exp_cpu ? 32'h1 : 32'h2);
      cyc();
      if (exp_cpu) cpu_rd_req = 1'b0;
    end
    lcd_rd_req = 1'b0; cpu_rd_req = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
